// File: rtl/rgb_fade_pkg.sv
// Shared types and the hue-wheel segment table for the RGB fade sequencer.
package rgb_fade_pkg;

  typedef enum logic [1:0] {CH_LO, CH_HI, CH_UP, CH_DN} ch_mode_t;

  localparam int SEG_COUNT = 6;

  typedef struct packed {
    ch_mode_t r;
    ch_mode_t g;
    ch_mode_t b;
  } seg_modes_t;

  // Exactly one channel ramps per segment; the other two hold the values the previous segment left behind.
  function automatic seg_modes_t seg_modes(input logic [2:0] seg);
    seg_modes_t m;
    case (seg)
      3'd0:    m = '{r: CH_HI, g: CH_UP, b: CH_LO};
      3'd1:    m = '{r: CH_DN, g: CH_HI, b: CH_LO};
      3'd2:    m = '{r: CH_LO, g: CH_HI, b: CH_UP};
      3'd3:    m = '{r: CH_LO, g: CH_DN, b: CH_HI};
      3'd4:    m = '{r: CH_UP, g: CH_LO, b: CH_HI};
      3'd5:    m = '{r: CH_HI, g: CH_LO, b: CH_DN};
      default: m = '{r: CH_LO, g: CH_LO, b: CH_LO};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_tick_timer.sv
// Free-running ramp-step timer; the counter only advances while enabled and is never cleared by disable.
module tick_timer #(
  parameter int TICK_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] r_count;
  logic          w_terminal;

  assign w_terminal = (r_count == CW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_terminal ? '0 : r_count + CW'(1);
    end
  end

  // Dropping enable in the terminal cycle defers the tick until terminal is next seen with enable high.
  assign tick = enable & w_terminal;

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Walks R/G/B levels around a six-segment hue wheel, one saturating ramp step per tick.
module rgb_fade_sequencer
  import rgb_fade_pkg::*;
#(
  parameter int PWM_INTERVAL = 1800,
  parameter int TICK_CYCLES  = 12000,
  parameter int STEP_SIZE    = 6,
  localparam int W           = $clog2(PWM_INTERVAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  output logic [W-1:0] r_value,
  output logic [W-1:0] g_value,
  output logic [W-1:0] b_value,
  output logic [2:0]   segment,
  output logic         segment_done
);

  localparam int MAX_LEVEL = PWM_INTERVAL - 1;

  if (STEP_SIZE < 1 || STEP_SIZE > MAX_LEVEL) begin : g_bad_step
    $error("STEP_SIZE must lie in 1..PWM_INTERVAL-1");
  end

  logic           w_tick;
  logic [2:0]     r_segment;
  logic [2:0]     w_segment_next;
  logic           r_done;
  logic           w_seg_end;
  logic [2:0]     w_hit;
  ch_mode_t       w_mode  [3];
  logic [W-1:0]   w_level [3];

  tick_timer #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_segment <= '0;
    end else begin
      r_segment <= w_segment_next;
    end
  end

  assign w_seg_end = w_tick & (|w_hit);

  always_comb begin
    w_segment_next = r_segment;
    if (w_seg_end) begin
      w_segment_next = (r_segment == 3'(SEG_COUNT - 1)) ? 3'd0 : r_segment + 3'd1;
    end
  end

  always_comb begin
    seg_modes_t w_m;
    w_m       = seg_modes(r_segment);
    w_mode[0] = w_m.r;
    w_mode[1] = w_m.g;
    w_mode[2] = w_m.b;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    localparam logic [W-1:0] RST_LVL = (gi == 0) ? W'(MAX_LEVEL) : '0;
    localparam logic [W:0]   UP_LIM  = (W+1)'(MAX_LEVEL - STEP_SIZE);

    logic [W-1:0] r_lvl;
    logic [W-1:0] w_nxt;
    logic         w_hit_ch;

    // The headroom compare is one bit wider so v+STEP never wraps before saturating.
    always_comb begin
      w_nxt    = r_lvl;
      w_hit_ch = 1'b0;
      case (w_mode[gi])
        CH_UP: begin
          w_nxt    = ({1'b0, r_lvl} > UP_LIM) ? W'(MAX_LEVEL) : r_lvl + W'(STEP_SIZE);
          w_hit_ch = (w_nxt == W'(MAX_LEVEL));
        end
        CH_DN: begin
          w_nxt    = (r_lvl < W'(STEP_SIZE)) ? '0 : r_lvl - W'(STEP_SIZE);
          w_hit_ch = (w_nxt == '0);
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_lvl <= RST_LVL;
      end else if (w_tick) begin
        r_lvl <= w_nxt;
      end
    end

    assign w_hit[gi]   = w_hit_ch;
    assign w_level[gi] = r_lvl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_seg_end;
    end
  end

  assign r_value      = w_level[0];
  assign g_value      = w_level[1];
  assign b_value      = w_level[2];
  assign segment      = r_segment;
  assign segment_done = r_done;

endmodule
